// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder/subtractor. The two WIDTH-bit operands are latched on
//   start. The unit then adds DIGIT bits per clock, keeping the carry in a
//   register between digits. After WIDTH/DIGIT steps it presents sum,
//   carry-out and signed overflow, and raises a one-cycle done pulse.
//   Subtraction is computed as A + ~B + ~cin.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      launch an operation (ignored while busy)
//   a      in   WIDTH  operand A, sampled with start
//   b      in   WIDTH  operand B, sampled with start
//   cin    in   1      carry-in, sampled with start
//   sub    in   1      0: A+B+cin, 1: A-B-cin, sampled with start
//   busy   out  1      operation in progress
//   done   out  1      one-cycle result-valid pulse
//   sum    out  WIDTH  result, held from one done to the next
//   cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ripple add of one digit. Returns {carry into top bit, carry out, sum}.
    // The carry into the top bit of the last digit is the carry into the MSB.
    function automatic logic [DIGIT+1:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c_in
    );
        logic [DIGIT-1:0] s;
        logic             c;
        logic             c_top;
        s     = '0;
        c     = c_in;
        c_top = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            c_top = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c_top, c, s};
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT+1:0] step_s;
    logic [WIDTH-1:0] dig_ext_s;
    logic [WIDTH-1:0] acc_shift_s;

    // Current digit: low DIGIT bits of both operands plus the running carry.
    always_comb begin
        step_s      = digit_add(opa_q[DIGIT-1:0], opb_q[DIGIT-1:0], carry_q);
        dig_ext_s   = WIDTH'(step_s[DIGIT-1:0]);
        // Result digits enter at the MSB end so that after N steps the first
        // digit has arrived at bit 0.
        acc_shift_s = (acc_q >> DIGIT) | (dig_ext_s << (WIDTH - DIGIT));
    end

    // Next-state, operand shifting and result capture.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = step_s[DIGIT];
                acc_d   = acc_shift_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    sum_d   = acc_shift_s;
                    cout_d  = step_s[DIGIT];
                    ovf_d   = step_s[DIGIT+1] ^ step_s[DIGIT];
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Five serial_adder instances: (W,D) = (8,1) (8,4) (4,1) (4,2) (4,4).
//   Stimulus pushes expected results (value and arrival cycle) into one
//   queue per instance. A forked monitor pops on every done pulse and
//   checks that the outputs do not change between done pulses.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [4:0]      start_s, cin_s, sub_s;
    logic [4:0]      busy_a, done_a, cout_a, ovf_a;
    logic [4:0][7:0] a_s, b_s, sum_a;

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_at_edge <= rst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  sum;
        logic        cout;
        logic        ovf;
        logic [31:0] due;
    } exp_t;

    exp_t exp_q [5][$];

    function automatic int w_of(input int g);
        return (g < 2) ? 8 : 4;
    endfunction

    function automatic int d_of(input int g);
        return (g == 1 || g == 4) ? 4 : ((g == 3) ? 2 : 1);
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int W = (g < 2) ? 8 : 4;
        localparam int D = (g == 1 || g == 4) ? 4 : ((g == 3) ? 2 : 1);
        logic [W-1:0] sum_w;
        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_s[g]),
            .a     (a_s[g][W-1:0]),
            .b     (b_s[g][W-1:0]),
            .cin   (cin_s[g]),
            .sub   (sub_s[g]),
            .busy  (busy_a[g]),
            .done  (done_a[g]),
            .sum   (sum_w),
            .cout  (cout_a[g]),
            .ovf   (ovf_a[g])
        );
        assign sum_a[g] = 8'(sum_w);
    end

    // Reference: plain integer arithmetic on the operands currently applied to instance g.
    function automatic exp_t ref_op(input int g, input int due);
        int   w, m, ua, ub, sa, sb, c, full, sres;
        exp_t e;
        w  = w_of(g);
        m  = 1 << w;
        ua = int'(a_s[g]) % m;
        ub = int'(b_s[g]) % m;
        c  = int'(cin_s[g]);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub_s[g]) begin
            full = ua - ub - c + m;
            sres = sa - sb - c;
        end else begin
            full = ua + ub + c;
            sres = sa + sb + c;
        end
        e.sum  = 8'(full % m);
        e.cout = (full >= m);
        e.ovf  = (sres >= m / 2) || (sres < -(m / 2));
        e.due  = 32'(due);
        return e;
    endfunction

    task automatic drive(input int g, input logic [7:0] av, input logic [7:0] bv,
                         input logic c, input logic s);
        a_s[g]     = av;
        b_s[g]     = bv;
        cin_s[g]   = c;
        sub_s[g]   = s;
        start_s[g] = 1'b1;
    endtask

    // Let the start edge happen, then record expectations for the launched ops.
    task automatic commit(input logic [4:0] push);
        @(posedge clk);
        #1;
        for (int g = 0; g < 5; g++) begin
            if (start_s[g]) begin
                if (push[g]) exp_q[g].push_back(ref_op(g, cyc + w_of(g) / d_of(g)));
                start_s[g] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (busy_a == 5'd0) && (done_a == 5'd0);
            for (int g = 0; g < 5; g++) if (exp_q[g].size() != 0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b done=%b after 200 cycles, required all idle", busy_a, done_a);
        end
    endtask

    task automatic run_dir(input int g, input logic [7:0] av, input logic [7:0] bv,
                           input logic c, input logic s, input logic [7:0] es,
                           input logic ec, input logic eo);
        @(negedge clk);
        drive(g, av, bv, c, s);
        commit(5'b1 << g);
        wait_idle();
        checks++;
        if (sum_a[g] !== es || cout_a[g] !== ec || ovf_a[g] !== eo) begin
            errors++;
            $display("FAIL directed dut%0d %h/%h: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     g, av, bv, sum_a[g], cout_a[g], ovf_a[g], es, ec, eo);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_sum [5];
        logic       prev_co  [5];
        logic       prev_ov  [5];
        rst     = 1'b1;
        start_s = 5'd0;
        cin_s   = 5'd0;
        sub_s   = 5'd0;
        a_s     = '0;
        b_s     = '0;

        // Monitor: score each done pulse and check output holding.
        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 5; g++) begin
                    if (done_a[g]) begin
                        checks++;
                        if (exp_q[g].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_done dut%0d: done=1 at cycle %0d, required no done", g, cyc);
                        end else begin
                            exp_t e;
                            e = exp_q[g].pop_front();
                            if (sum_a[g] !== e.sum || cout_a[g] !== e.cout || ovf_a[g] !== e.ovf || cyc != int'(e.due)) begin
                                errors++;
                                $display("FAIL result dut%0d: got sum=%h cout=%b ovf=%b cycle=%0d, required sum=%h cout=%b ovf=%b cycle=%0d",
                                         g, sum_a[g], cout_a[g], ovf_a[g], cyc, e.sum, e.cout, e.ovf, int'(e.due));
                            end
                        end
                    end else if (!rst_at_edge) begin
                        checks++;
                        if ({sum_a[g], cout_a[g], ovf_a[g]} !== {prev_sum[g], prev_co[g], prev_ov[g]}) begin
                            errors++;
                            $display("FAIL hold dut%0d: outputs changed to sum=%h cout=%b ovf=%b without done, required sum=%h cout=%b ovf=%b",
                                     g, sum_a[g], cout_a[g], ovf_a[g], prev_sum[g], prev_co[g], prev_ov[g]);
                        end
                    end
                    prev_sum[g] = sum_a[g];
                    prev_co[g]  = cout_a[g];
                    prev_ov[g]  = ovf_a[g];
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (busy_a[g] !== 1'b0 || done_a[g] !== 1'b0 || sum_a[g] !== 8'h00 || cout_a[g] !== 1'b0 || ovf_a[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                         g, busy_a[g], done_a[g], sum_a[g], cout_a[g], ovf_a[g]);
            end
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed examples
        run_dir(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_dir(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_dir(0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run_dir(1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_dir(1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // start pulsed mid-run with new operands: ignored
        @(negedge clk);
        drive(0, 8'h3C, 8'h21, 1'b0, 1'b0);
        commit(5'b00001);
        repeat (3) @(negedge clk);
        drive(0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        wait_idle();

        // Back-to-back: start held through DONE, second op starts without an IDLE cycle
        @(negedge clk);
        drive(0, 8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        exp_q[0].push_back(ref_op(0, cyc + 8));
        a_s[0]   = 8'h40;
        b_s[0]   = 8'h0F;
        cin_s[0] = 1'b1;
        sub_s[0] = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        exp_q[0].push_back(ref_op(0, cyc + 8));
        start_s[0] = 1'b0;
        wait_idle();

        // Randomized operations on the 8-bit instances
        repeat (150) begin
            @(negedge clk);
            drive(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) != 0) drive(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            commit(5'b00011);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a run: operation discarded, no done
        run_dir(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 8'h55, 8'h0A, 1'b0, 1'b0);
        commit(5'b00000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || sum_a[0] !== 8'h00 || cout_a[0] !== 1'b0 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy_a[0], done_a[0], sum_a[0], cout_a[0], ovf_a[0]);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle();

        // Exhaustive 4-bit sweep on D = 1, 2, 4 in parallel
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cs = 0; cs < 4; cs++) begin
                    @(negedge clk);
                    for (int g = 2; g < 5; g++) drive(g, 8'(av), 8'(bv), cs[0], cs[1]);
                    commit(5'b11100);
                    wait_idle();
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
